// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer controller.
// Pure declarations; no logic, no latency.
// No flow control; consumed by the button detector and the timer top.
package timer_pkg;

  // Timer state encoding; the 2-bit value is exported on the state port.
  typedef enum logic [1:0] {
    SET   = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    BEEP  = 2'b11
  } timer_state_t;

  // Shift-register pattern for a button release: high last cycle, low now.
  localparam logic [1:0] BTN_REL = 2'b10;

endpackage

// File: rtl/btn_release_detect.sv
// Button release detector: 2-flop shift register plus release compare.
// Latency: rel is high in the cycle after the edge that samples the button low.
// No backpressure; rel is a single-cycle event per release.
module btn_release_detect
  import timer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rel
);

  logic [1:0] sr;

  // Shift in the button level; older sample in bit 1.
  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= {sr[0], btn};
  end

  assign rel = (sr == BTN_REL);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: SET/RUN/PAUSE/BEEP FSM, tick prescaler, auto-reload.
// Latency: button events act one edge after detection; done/beep are registered.
// No backpressure; inputs are level buttons, outputs are free-running registers.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int SET_W       = 9,
  parameter int SCALE       = 100,
  parameter int CNT_W       = 16,
  parameter int TICK_DIV    = 1,
  parameter int BEEP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SET_W-1:0] set_val,
  input  logic             btn_go,
  input  logic             btn_clr,
  input  logic             reload_en,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state,
  output logic             beep,
  output logic             done
);

  localparam int P_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BC_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [P_W-1:0]   TICK_LAST = P_W'(TICK_DIV - 1);
  localparam logic [BC_W-1:0]  BEEP_LAST = BC_W'((BEEP_CYCLES > 0) ? BEEP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SCALE_C   = CNT_W'(SCALE);

  // The largest possible start count must fit in the counter.
  localparam longint MAX_START = ((longint'(1) << SET_W) - 1) * longint'(SCALE);
  localparam longint CNT_LIM   = longint'(1) << CNT_W;

  if (MAX_START >= CNT_LIM) begin : g_bad_cnt_w
    $error("countdown_timer_ctrl: CNT_W too narrow for (2**SET_W-1)*SCALE");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("countdown_timer_ctrl: TICK_DIV must be at least 1");
  end

  timer_state_t     state_q;
  logic [CNT_W-1:0] load_r;
  logic [CNT_W-1:0] scaled;
  logic [P_W-1:0]   presc;
  logic [BC_W-1:0]  beep_cnt;
  logic             go_ev;
  logic             clr_ev;

  btn_release_detect u_go (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_go),
    .rel   (go_ev)
  );

  btn_release_detect u_clr (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clr),
    .rel   (clr_ev)
  );

  // Product is formed at counter width; the width check above keeps it exact.
  assign scaled = CNT_W'(set_val) * SCALE_C;

  // Main FSM: state, count, reload value, prescaler, beep window and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SET;
      count    <= '0;
      load_r   <= '0;
      presc    <= '0;
      beep_cnt <= '0;
      beep     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        SET: begin
          presc    <= '0;
          beep_cnt <= '0;
          if (go_ev && !clr_ev) begin
            // Hold count on the start edge so load_r and count agree.
            state_q <= RUN;
            load_r  <= count;
          end else begin
            count <= scaled;
          end
        end
        RUN: begin
          if (clr_ev) begin
            state_q <= SET;
            presc   <= '0;
          end else if (go_ev) begin
            // Prescaler keeps its phase so resume finishes the partial tick.
            state_q <= PAUSE;
          end else if (count == '0) begin
            done  <= 1'b1;
            presc <= '0;
            // A zero reload value would spin forever, so it falls to BEEP.
            if (reload_en && (load_r != '0)) begin
              count <= load_r;
            end else begin
              state_q  <= BEEP;
              count    <= '0;
              beep     <= 1'b1;
              beep_cnt <= '0;
            end
          end else if (presc == TICK_LAST) begin
            count <= count - CNT_W'(1);
            presc <= '0;
          end else begin
            presc <= presc + P_W'(1);
          end
        end
        PAUSE: begin
          if (clr_ev)     state_q <= SET;
          else if (go_ev) state_q <= RUN;
        end
        BEEP: begin
          count <= '0;
          presc <= '0;
          if (clr_ev || go_ev) begin
            state_q <= SET;
            beep    <= 1'b0;
          end else if ((BEEP_CYCLES > 0) && (beep_cnt == BEEP_LAST)) begin
            state_q <= SET;
            beep    <= 1'b0;
          end else if (BEEP_CYCLES > 0) begin
            beep_cnt <= beep_cnt + BC_W'(1);
          end
        end
        default: begin
          state_q <= SET;
          beep    <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with TICK_DIV=4, BEEP_CYCLES=8.
// Inputs change 1ns after the rising edge; outputs are checked at that point.
// Buttons are pressed for one cycle and released; action lands 3 edges later.
module tb_countdown_timer_ctrl;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  set_val;
  logic        btn_go;
  logic        btn_clr;
  logic        reload_en;
  logic [15:0] count;
  logic [1:0]  state;
  logic        beep;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(
    .SET_W(9), .SCALE(100), .CNT_W(16), .TICK_DIV(4), .BEEP_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .set_val   (set_val),
    .btn_go    (btn_go),
    .btn_clr   (btn_clr),
    .reload_en (reload_en),
    .count     (count),
    .state     (state),
    .beep      (beep),
    .done      (done)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_go();
    btn_go = 1'b1; step(1); btn_go = 1'b0; step(2);
  endtask

  task automatic release_clr();
    btn_clr = 1'b1; step(1); btn_clr = 1'b0; step(2);
  endtask

  task automatic release_both();
    btn_go = 1'b1; btn_clr = 1'b1; step(1);
    btn_go = 1'b0; btn_clr = 1'b0; step(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; set_val = 9'd3; reload_en = 1'b0;
    step(2);
    n_cmp++; if (state !== 2'(SET)) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (beep !== 1'b0) begin n_bad++; $display("FAIL reset_beep: got %0b want 0", beep); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_set_track();
    set_val = 9'd3; step(1);
    n_cmp++; if (count !== 16'd300) begin n_bad++; $display("FAIL set_track_300: got %0d want 300", count); end
    set_val = 9'd5; step(1);
    n_cmp++; if (count !== 16'd500) begin n_bad++; $display("FAIL set_track_500: got %0d want 500", count); end
    set_val = 9'd3; step(1);
    n_cmp++; if (count !== 16'd300) begin n_bad++; $display("FAIL set_track_back: got %0d want 300", count); end
  endtask

  task automatic test_run_pause();
    release_go();                       // entry edge E
    n_cmp++; if (state !== 2'(RUN)) begin n_bad++; $display("FAIL run_entry_state: got %0d want 1", state); end
    n_cmp++; if (count !== 16'd300) begin n_bad++; $display("FAIL run_entry_count: got %0d want 300", count); end
    step(3);                            // E+3
    n_cmp++; if (count !== 16'd300) begin n_bad++; $display("FAIL run_e3: got %0d want 300", count); end
    step(1);                            // E+4
    n_cmp++; if (count !== 16'd299) begin n_bad++; $display("FAIL run_e4: got %0d want 299", count); end
    step(4);                            // E+8
    n_cmp++; if (count !== 16'd298) begin n_bad++; $display("FAIL run_e8: got %0d want 298", count); end
    step(192);                          // E+200, prescaler phase 0
    n_cmp++; if (count !== 16'd250) begin n_bad++; $display("FAIL run_e200: got %0d want 250", count); end
    release_go();                       // PAUSE from E+203, phase 2 held
    n_cmp++; if (state !== 2'(PAUSE)) begin n_bad++; $display("FAIL pause_state: got %0d want 2", state); end
    n_cmp++; if (count !== 16'd250) begin n_bad++; $display("FAIL pause_count: got %0d want 250", count); end
    step(10);
    n_cmp++; if (state !== 2'(PAUSE)) begin n_bad++; $display("FAIL pause_hold_state: got %0d want 2", state); end
    n_cmp++; if (count !== 16'd250) begin n_bad++; $display("FAIL pause_hold_count: got %0d want 250", count); end
    release_go();                       // RUN re-entry edge R
    n_cmp++; if (state !== 2'(RUN)) begin n_bad++; $display("FAIL resume_state: got %0d want 1", state); end
    step(1);
    n_cmp++; if (count !== 16'd250) begin n_bad++; $display("FAIL resume_r1: got %0d want 250", count); end
    step(1);
    n_cmp++; if (count !== 16'd249) begin n_bad++; $display("FAIL resume_r2: got %0d want 249", count); end
  endtask

  task automatic test_clr_and_go();
    release_both();
    n_cmp++; if (state !== 2'(SET)) begin n_bad++; $display("FAIL both_state: got %0d want 0", state); end
    step(1);
    n_cmp++; if (count !== 16'd300) begin n_bad++; $display("FAIL both_count: got %0d want 300", count); end
  endtask

  task automatic test_beep_expiry();
    int dpulses;
    set_val = 9'd1; reload_en = 1'b0; step(1);
    n_cmp++; if (count !== 16'd100) begin n_bad++; $display("FAIL beep_setup: got %0d want 100", count); end
    release_go();                       // E
    step(399);
    n_cmp++; if (count !== 16'd1) begin n_bad++; $display("FAIL beep_e399: got %0d want 1", count); end
    step(1);
    n_cmp++; if (count !== 16'd0 || state !== 2'(RUN) || done !== 1'b0) begin n_bad++;
      $display("FAIL beep_zero: count=%0d state=%0d done=%0b want 0/1/0", count, state, done); end
    step(1);
    n_cmp++; if (done !== 1'b1 || state !== 2'(BEEP) || beep !== 1'b1) begin n_bad++;
      $display("FAIL beep_enter: done=%0b state=%0d beep=%0b want 1/3/1", done, state, beep); end
    dpulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (done === 1'b1) dpulses++;
      n_cmp++; if (beep !== 1'b1 || count !== 16'd0) begin n_bad++;
        $display("FAIL beep_window_%0d: beep=%0b count=%0d want 1/0", i, beep, count); end
    end
    n_cmp++; if (dpulses !== 0) begin n_bad++; $display("FAIL beep_done_once: extra pulses %0d want 0", dpulses); end
    step(1);
    n_cmp++; if (state !== 2'(SET) || beep !== 1'b0) begin n_bad++;
      $display("FAIL beep_exit: state=%0d beep=%0b want 0/0", state, beep); end
    step(1);
    n_cmp++; if (count !== 16'd100) begin n_bad++; $display("FAIL beep_reload_set: got %0d want 100", count); end
  endtask

  task automatic test_reload();
    set_val = 9'd1; reload_en = 1'b1; step(1);
    release_go();                       // E
    step(400);
    n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL reload_zero: got %0d want 0", count); end
    step(1);                            // E+401
    n_cmp++; if (done !== 1'b1 || count !== 16'd100 || state !== 2'(RUN)) begin n_bad++;
      $display("FAIL reload_hit: done=%0b count=%0d state=%0d want 1/100/1", done, count, state); end
    step(1);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reload_done_low: got %0b want 0", done); end
    step(2);                            // E+404
    n_cmp++; if (count !== 16'd100) begin n_bad++; $display("FAIL reload_e404: got %0d want 100", count); end
    step(1);                            // E+405
    n_cmp++; if (count !== 16'd99) begin n_bad++; $display("FAIL reload_e405: got %0d want 99", count); end
    release_clr();
    n_cmp++; if (state !== 2'(SET)) begin n_bad++; $display("FAIL reload_clr: got %0d want 0", state); end
  endtask

  task automatic test_zero_setting();
    set_val = 9'd0; reload_en = 1'b1; step(1);
    release_go();                       // E
    n_cmp++; if (state !== 2'(RUN) || count !== 16'd0) begin n_bad++;
      $display("FAIL zero_entry: state=%0d count=%0d want 1/0", state, count); end
    step(1);
    n_cmp++; if (state !== 2'(BEEP) || done !== 1'b1) begin n_bad++;
      $display("FAIL zero_beep: state=%0d done=%0b want 3/1", state, done); end
    step(1);
    n_cmp++; if (done !== 1'b0 || state !== 2'(BEEP)) begin n_bad++;
      $display("FAIL zero_no_spin: done=%0b state=%0d want 0/3", done, state); end
    release_clr();
    n_cmp++; if (state !== 2'(SET) || beep !== 1'b0) begin n_bad++;
      $display("FAIL zero_clr: state=%0d beep=%0b want 0/0", state, beep); end
  endtask

  task automatic test_reset_mid_run();
    set_val = 9'd3; reload_en = 1'b0; step(1);
    release_go();                       // E
    step(600);
    n_cmp++; if (count !== 16'd150) begin n_bad++; $display("FAIL mid_run_count: got %0d want 150", count); end
    reset = 1'b1; set_val = 9'd2;
    step(1);
    n_cmp++; if (state !== 2'(SET) || count !== 16'd0 || beep !== 1'b0 || done !== 1'b0) begin n_bad++;
      $display("FAIL mid_run_reset: state=%0d count=%0d beep=%0b done=%0b want 0/0/0/0", state, count, beep, done); end
    reset = 1'b0;
    step(1);
    n_cmp++; if (count !== 16'd200 || state !== 2'(SET)) begin n_bad++;
      $display("FAIL post_reset_track: count=%0d state=%0d want 200/0", count, state); end
  endtask

  initial begin
    reset = 1'b1; set_val = '0; btn_go = 1'b0; btn_clr = 1'b0; reload_en = 1'b0;
    test_reset();
    test_set_track();
    test_run_pause();
    test_clr_and_go();
    test_beep_expiry();
    test_reload();
    test_zero_setting();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Parametrised single-channel countdown timer controller: loads a user setting scaled by `SCALE`, counts down at a prescaled tick rate, and supports start/pause/clear from debounced-level push buttons. Over the previous controller it adds a tick prescaler, optional auto-reload, a one-cycle `done` pulse, a timed beep window, and zero-setting protection. It sits between the switch/button inputs and the display-drive logic of the lab timer.

## Interface
- `SET_W`, 9, width of the user setting input.
- `SCALE`, 100, multiplier applied to the setting to form the start count.
- `CNT_W`, 16, count width. Constraint: `(2**SET_W-1)*SCALE < 2**CNT_W`, checked by elaboration assertion.
- `TICK_DIV`, 1, clock cycles per count decrement (≥1).
- `BEEP_CYCLES`, 0, beep duration in cycles. 0 means beep until cleared.
- `clk  in  1  system clock`
- `reset  in  1  synchronous, active-high reset`
- `set_val  in  SET_W  user setting, sampled continuously in SET`
- `btn_go  in  1  start/pause/acknowledge button; acts on release`
- `btn_clr  in  1  clear-to-SET button; acts on release`
- `reload_en  in  1  auto-reload on expiry when high`
- `count  out  CNT_W  registered current count`
- `state  out  2  current state (timer_state_t)`
- `beep  out  1  high while in BEEP`
- `done  out  1  one-cycle pulse on expiry`

## Operation
- Each button passes through a 2-bit shift register, `sr <= {sr[0], btn}`. An event fires when `sr == 2'b10` (release).
- States:
  - SET (00): `count <= set_val*SCALE` every cycle. go → RUN, with `load_r <= count`.
  - RUN (01): count decrements on each tick. clr → SET; go → PAUSE.
    - Expiry is `count == 0` with no button event.
    - On expiry with `reload_en=1` and `load_r != 0`: `count <= load_r`, stay in RUN.
    - Otherwise on expiry: go to BEEP with `count <= 0`.
    - `done` pulses on every expiry.
  - PAUSE (10): count and prescaler hold. clr → SET; go → RUN.
  - BEEP (11): `beep=1`, `count=0`. clr or go → SET. If `BEEP_CYCLES>0`, auto-return to SET after exactly `BEEP_CYCLES` cycles in BEEP.
- Priority inside a state: clr > go > expiry > tick decrement.
- Prescaler:
  - Counts 0..`TICK_DIV-1` only in RUN; tick when it equals `TICK_DIV-1`.
  - Holds in PAUSE, so phase is preserved across pause/resume.
  - Cleared in SET and BEEP, and on reload.
- Arithmetic: `set_val*SCALE` is computed at `CNT_W` bits. Decrement never occurs at 0 (expiry takes precedence), so the count cannot wrap.
- Reset: `state=SET`, `count=0`, `beep=0`, `done=0`; shift registers, prescaler, `load_r` and beep counter all 0. Takes effect from any state, including mid-RUN and mid-BEEP.

## Timing
- Button release sampled low at edge k: event is valid in the cycle after k; state changes at edge k+1.
- `count` tracks `set_val` with one-cycle latency in SET.
- First decrement occurs `TICK_DIV` cycles after entering RUN (fresh start) or after the remaining prescaler phase (resume).
- Expiry is detected in the cycle where `count == 0` in RUN. `done` and the next state/count update at the following edge.
- `beep` is registered with the state (same-cycle as `state == BEEP`).
- `done` is registered and is high for exactly one cycle per expiry.

## Structure
- Package `timer_pkg`:
  - `typedef enum logic [1:0] timer_state_t {SET=2'b00, RUN=2'b01, PAUSE=2'b10, BEEP=2'b11}`.
  - Shared event encoding constant `BTN_REL = 2'b10`.
- Sub-module `btn_release_detect`: a 2-flop shift register plus release compare. Instantiated twice (go, clr).
- Top-level module holds the FSM, prescaler, count/load registers and beep counter.

## Test plan
- Params SET_W=9, SCALE=100, CNT_W=16, TICK_DIV=4: `set_val=3` → `count=300` one cycle later; release go → RUN; `count=299` 4 cycles after entry, 298 after 8.
- Pause at `count=250` with prescaler phase 2 → count holds 10 cycles in PAUSE; go → RUN; `count=249` exactly 2 cycles after RUN re-entry.
- `set_val=1`, `reload_en=0`, `BEEP_CYCLES=8`: count reaches 0 → single `done` pulse, BEEP with `beep=1` for exactly 8 cycles, then SET with `count=100`.
- `set_val=1`, `reload_en=1`: at expiry `done` pulses, `count=100`, state stays RUN, decrement resumes 4 cycles later.
- `set_val=0`, `reload_en=1`, go → RUN → BEEP within 2 cycles with one `done` (no reload spin). Simultaneous go and clr releases in RUN → SET.
- Assert `reset` mid-RUN at `count=150` → next edge `state=SET`, `count=0`, `beep=0`, `done=0`; `count=set_val*100` one cycle after `reset` drops.
